// File: rtl/cache_level_ctrl.sv
// Set-associative cache tag/state controller with FIFO or LRU replacement and write-through or write-back policy.
// Optional statistics counters are built only when CACHE_LEVEL_STATS_EN is defined.
module cache_level_ctrl #(
  parameter int ADDR_W      = 48,
  parameter int NUMSETS     = 256,
  parameter int ASSOC       = 4,
  parameter int BLOCK_BYTES = 64,
  parameter int CNT_W       = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_policy,
  input  logic              replace_policy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CNT_W-1:0]  reads,
  output logic [CNT_W-1:0]  writes,
  output logic [CNT_W-1:0]  hits,
  output logic [CNT_W-1:0]  misses,
  output logic [CNT_W-1:0]  writebacks
);

  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(NUMSETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;
  localparam logic [WAY_W-1:0]  AGE_MAX  = WAY_W'(ASSOC - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_EVICT, S_FILL, S_STORE, S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q, wp_q, rp_q, hit_q;
  logic [WAY_W-1:0]  way_q;
  logic [TAG_W-1:0]  vtag_q;

  logic [ASSOC-1:0]  valid_q [NUMSETS];
  logic [ASSOC-1:0]  dirty_q [NUMSETS];
  logic [WAY_W-1:0]  age_q   [NUMSETS][ASSOC];
  logic [TAG_W-1:0]  tag_q   [NUMSETS][ASSOC];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic [ASSOC-1:0]  hit_vec;
  logic [WAY_W-1:0]  set_age [ASSOC];
  logic              any_hit;
  logic [WAY_W-1:0]  hit_way, victim;
  logic              victim_dirty;
  logic [WAY_W-1:0]  lru_age  [ASSOC];
  logic [WAY_W-1:0]  fill_age [ASSOC];

  assign idx     = addr_q[OFF_W +: IDX_W];
  assign req_tag = addr_q[ADDR_W-1 -: TAG_W];

  for (genvar gi = 0; gi < ASSOC; gi++) begin : g_way
    assign hit_vec[gi] = valid_q[idx][gi] && (tag_q[idx][gi] == req_tag);
    assign set_age[gi] = age_q[idx][gi];
  end

  assign any_hit = |hit_vec;

  always_comb begin
    logic             found_inv;
    logic [WAY_W-1:0] max_age;
    hit_way   = '0;
    victim    = '0;
    found_inv = 1'b0;
    max_age   = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    // First invalid way wins; otherwise the oldest way, lowest index on ties.
    for (int w = 0; w < ASSOC; w++) begin
      if (!found_inv && !valid_q[idx][w]) begin
        victim    = WAY_W'(w);
        found_inv = 1'b1;
      end
    end
    if (!found_inv) begin
      max_age = set_age[0];
      for (int w = 1; w < ASSOC; w++) begin
        if (set_age[w] > max_age) begin
          max_age = set_age[w];
          victim  = WAY_W'(w);
        end
      end
    end
    victim_dirty = valid_q[idx][victim] && dirty_q[idx][victim];
    for (int w = 0; w < ASSOC; w++) begin
      lru_age[w]  = set_age[w];
      fill_age[w] = set_age[w];
      if (WAY_W'(w) == hit_way) begin
        lru_age[w] = '0;
      end else if (valid_q[idx][w] && (set_age[w] < set_age[hit_way]) && (set_age[w] != AGE_MAX)) begin
        lru_age[w] = set_age[w] + 1'b1;
      end
      if (WAY_W'(w) == way_q) begin
        fill_age[w] = '0;
      end else if (valid_q[idx][w] && (set_age[w] != AGE_MAX)) begin
        fill_age[w] = set_age[w] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = reset;
        if (req_valid) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (any_hit) state_d = (we_q && !wp_q) ? S_STORE : S_RESP;
        else         state_d = victim_dirty ? S_EVICT : S_FILL;
      end
      S_EVICT: begin
        mem_valid = reset;
        mem_we    = 1'b1;
        mem_addr  = {vtag_q, idx, {OFF_W{1'b0}}};
        if (mem_ready) state_d = S_FILL;
      end
      S_FILL: begin
        mem_valid = reset;
        mem_addr  = addr_q & BLK_MASK;
        if (mem_ready) state_d = (we_q && !wp_q) ? S_STORE : S_RESP;
      end
      S_STORE: begin
        mem_valid = reset;
        mem_we    = 1'b1;
        mem_addr  = addr_q & BLK_MASK;
        if (mem_ready) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = reset;
        resp_hit   = hit_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      hit_q   <= 1'b0;
      way_q   <= '0;
      vtag_q  <= '0;
      for (int s = 0; s < NUMSETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < ASSOC; w++) age_q[s][w] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            we_q   <= req_we;
            wp_q   <= write_policy;
            rp_q   <= replace_policy;
          end
        end
        S_LOOKUP: begin
          hit_q <= any_hit;
          if (any_hit) begin
            way_q <= hit_way;
            if (rp_q) begin
              for (int w = 0; w < ASSOC; w++) age_q[idx][w] <= lru_age[w];
            end
            if (we_q && wp_q) dirty_q[idx][hit_way] <= 1'b1;
          end else begin
            way_q  <= victim;
            vtag_q <= tag_q[idx][victim];
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            valid_q[idx][way_q] <= 1'b1;
            dirty_q[idx][way_q] <= we_q && wp_q;
            for (int w = 0; w < ASSOC; w++) age_q[idx][w] <= fill_age[w];
          end
        end
        default: ;
      endcase
    end
  end

  // Tags need no reset: a way is only consulted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (reset && (state_q == S_FILL) && mem_ready) tag_q[idx][way_q] <= req_tag;
  end

`ifdef CACHE_LEVEL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] reads_q, writes_q, hits_q, misses_q, wbs_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      reads_q  <= '0;
      writes_q <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      if ((state_q == S_IDLE) && req_valid) begin
        if (req_we) writes_q <= sat_inc(writes_q);
        else        reads_q  <= sat_inc(reads_q);
      end
      if (state_q == S_LOOKUP) begin
        if (any_hit) hits_q   <= sat_inc(hits_q);
        else         misses_q <= sat_inc(misses_q);
      end
      if ((state_q == S_EVICT) && mem_ready) wbs_q <= sat_inc(wbs_q);
    end
  end

  assign reads      = reads_q;
  assign writes     = writes_q;
  assign hits       = hits_q;
  assign misses     = misses_q;
  assign writebacks = wbs_q;
`else
  assign reads      = '0;
  assign writes     = '0;
  assign hits       = '0;
  assign misses     = '0;
  assign writebacks = '0;
`endif

endmodule

// File: tb/tb_cache_level_ctrl.sv
// Scoreboard bench for cache_level_ctrl: expected hit flag and memory-access sequence queued per request.
module tb_cache_level_ctrl;
  localparam int AW = 48;
  localparam int CW = 4;

  typedef struct packed {
    logic            hit;
    logic [1:0]      n;
    logic [2:0][AW:0] acc;
  } exp_t;

  localparam logic [AW:0] NA = '0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic write_policy = 1'b0, replace_policy = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, mem_ready = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic req_ready, resp_valid, resp_hit, mem_valid, mem_we;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] reads, writes, hits, misses, writebacks;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t exp_q[$];
  logic [AW:0] obs_q[$];
  exp_t mon_e;

  cache_level_ctrl #(
    .ADDR_W(AW), .NUMSETS(256), .ASSOC(4), .BLOCK_BYTES(64), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .write_policy(write_policy), .replace_policy(replace_policy),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .reads(reads), .writes(writes), .hits(hits), .misses(misses), .writebacks(writebacks)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int v);
`ifdef CACHE_LEVEL_STATS_EN
    return (v > (1 << CW) - 1) ? 64'((1 << CW) - 1) : 64'(v);
`else
    return 64'(v) & 64'd0;
`endif
  endfunction

  function automatic logic [AW:0] fl(input logic [AW-1:0] a);
    return {1'b0, a};
  endfunction

  function automatic logic [AW:0] st(input logic [AW-1:0] a);
    return {1'b1, a};
  endfunction

  function automatic exp_t mk(input logic h, input int n, input logic [AW:0] a0, input logic [AW:0] a1,
                              input logic [AW:0] a2);
    exp_t e;
    e.hit = h;
    e.n = 2'(n);
    e.acc[0] = a0;
    e.acc[1] = a1;
    e.acc[2] = a2;
    return e;
  endfunction

  task automatic check_cnts(input int r, input int w, input int h, input int m, input int wb);
    check_eq("cnt_reads", 64'(reads), exp_cnt(r));
    check_eq("cnt_writes", 64'(writes), exp_cnt(w));
    check_eq("cnt_hits", 64'(hits), exp_cnt(h));
    check_eq("cnt_misses", 64'(misses), exp_cnt(m));
    check_eq("cnt_writebacks", 64'(writebacks), exp_cnt(wb));
  endtask

  // Scoreboard: memory handshakes are collected, then matched against the queued expectation at resp_valid.
  always @(negedge clk) begin
    if (!reset) begin
      obs_q.delete();
    end else begin
      if (mem_valid && mem_ready) obs_q.push_back({mem_we, mem_addr});
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_resp", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("resp: hit=%0b mem_accesses=%0d", resp_hit, obs_q.size());
          check_eq("resp_hit", 64'(resp_hit), 64'(mon_e.hit));
          check_eq("mem_access_count", 64'(obs_q.size()), 64'(mon_e.n));
          for (int i = 0; i < int'(mon_e.n); i++) begin
            if (i < obs_q.size()) check_eq("mem_access", 64'(obs_q[i]), 64'(mon_e.acc[i]));
          end
        end
        obs_q.delete();
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_resp_hit", 64'(resp_hit), 64'd0);
    check_eq("rst_mem_valid", 64'(mem_valid), 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_cnts(0, 0, 0, 0, 0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic we, input logic wp, input logic rp,
                        input exp_t e, input int stall);
    int acc_cyc, resp_cyc, ready_cyc, stalled;
    bit got;
    exp_q.push_back(e);
    if (stall > 0) mem_ready = 1'b0;
    req_addr = a;
    req_we = we;
    write_policy = wp;
    replace_policy = rp;
    req_valid = 1'b1;
    $display("req: addr=0x%0h we=%0b wp=%0b lru=%0b exp_hit=%0b", a, we, wp, rp, e.hit);
    got = 1'b0;
    acc_cyc = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!got) begin
      check_eq("accept_timeout", 64'd0, 64'd1);
      void'(exp_q.pop_back());
      req_valid = 1'b0;
      mem_ready = 1'b1;
    end else begin
      @(posedge clk);
      #1 req_valid = 1'b0;
      got = 1'b0;
      stalled = 0;
      ready_cyc = 0;
      resp_cyc = 0;
      for (int i = 0; i < 200 && !got; i++) begin
        @(negedge clk);
        if (resp_valid) begin
          got = 1'b1;
          resp_cyc = cyc;
        end else if (stall > 0 && mem_valid && stalled < stall) begin
          check_eq("stall_mem_addr", 64'(mem_addr), 64'(a & ~48'h3F));
          check_eq("stall_mem_we", 64'(mem_we), 64'd0);
          stalled++;
          if (stalled == stall) begin
            @(posedge clk);
            #1 mem_ready = 1'b1;
            ready_cyc = cyc;
          end
        end
      end
      if (!got) begin
        check_eq("resp_timeout", 64'd0, 64'd1);
        mem_ready = 1'b1;
      end else begin
        if (e.hit && !(we && !wp)) check_eq("hit_latency", 64'(resp_cyc - acc_cyc), 64'd2);
        if (stall > 0) check_eq("stall_resp_latency", 64'(resp_cyc - ready_cyc), 64'd1);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit resp_seen;

    // Cold miss then hit on the same block.
    do_reset();
    do_req(48'h1000, 1'b0, 1'b1, 1'b1, mk(1'b0, 1, fl(48'h1000), NA, NA), 0);
    do_req(48'h1000, 1'b0, 1'b1, 1'b1, mk(1'b1, 0, NA, NA, NA), 0);
    check_cnts(2, 0, 1, 1, 0);

    // Write-back with LRU in set 0: the line at 0x4000 is least recently used after re-reading 0x0000.
    do_reset();
    do_req(48'h0000, 1'b1, 1'b1, 1'b1, mk(1'b0, 1, fl(48'h0000), NA, NA), 0);
    do_req(48'h4000, 1'b0, 1'b1, 1'b1, mk(1'b0, 1, fl(48'h4000), NA, NA), 0);
    do_req(48'h8000, 1'b0, 1'b1, 1'b1, mk(1'b0, 1, fl(48'h8000), NA, NA), 0);
    do_req(48'hC000, 1'b0, 1'b1, 1'b1, mk(1'b0, 1, fl(48'hC000), NA, NA), 0);
    do_req(48'h003F, 1'b0, 1'b1, 1'b1, mk(1'b1, 0, NA, NA, NA), 0);
    do_req(48'h10000, 1'b1, 1'b1, 1'b1, mk(1'b0, 1, fl(48'h10000), NA, NA), 0);
    do_req(48'h4000, 1'b0, 1'b1, 1'b1, mk(1'b0, 1, fl(48'h4000), NA, NA), 0);
    do_req(48'h14000, 1'b0, 1'b1, 1'b1, mk(1'b0, 1, fl(48'h14000), NA, NA), 0);
    do_req(48'h18000, 1'b0, 1'b1, 1'b1, mk(1'b0, 2, st(48'h0000), fl(48'h18000), NA), 0);
    do_req(48'h0024, 1'b0, 1'b1, 1'b1, mk(1'b0, 2, st(48'h10000), fl(48'h0000), NA), 0);
    check_cnts(8, 2, 1, 9, 2);

    // Same sequence under FIFO: the oldest fill (0x0000, dirty) is evicted despite its hit.
    do_reset();
    do_req(48'h0000, 1'b1, 1'b1, 1'b0, mk(1'b0, 1, fl(48'h0000), NA, NA), 0);
    do_req(48'h4000, 1'b0, 1'b1, 1'b0, mk(1'b0, 1, fl(48'h4000), NA, NA), 0);
    do_req(48'h8000, 1'b0, 1'b1, 1'b0, mk(1'b0, 1, fl(48'h8000), NA, NA), 0);
    do_req(48'hC000, 1'b0, 1'b1, 1'b0, mk(1'b0, 1, fl(48'hC000), NA, NA), 0);
    do_req(48'h0000, 1'b0, 1'b1, 1'b0, mk(1'b1, 0, NA, NA, NA), 0);
    do_req(48'h10000, 1'b1, 1'b1, 1'b0, mk(1'b0, 2, st(48'h0000), fl(48'h10000), NA), 0);
    do_req(48'h4000, 1'b0, 1'b1, 1'b0, mk(1'b1, 0, NA, NA, NA), 0);
    check_cnts(5, 2, 2, 5, 1);

    // Write-through: store on write hit, clean eviction later, write miss allocates then stores.
    do_reset();
    do_req(48'h2000, 1'b0, 1'b0, 1'b1, mk(1'b0, 1, fl(48'h2000), NA, NA), 0);
    do_req(48'h2000, 1'b1, 1'b0, 1'b1, mk(1'b1, 1, st(48'h2000), NA, NA), 0);
    do_req(48'h6000, 1'b0, 1'b0, 1'b1, mk(1'b0, 1, fl(48'h6000), NA, NA), 0);
    do_req(48'hA000, 1'b0, 1'b0, 1'b1, mk(1'b0, 1, fl(48'hA000), NA, NA), 0);
    do_req(48'hE000, 1'b0, 1'b0, 1'b1, mk(1'b0, 1, fl(48'hE000), NA, NA), 0);
    do_req(48'h12000, 1'b0, 1'b0, 1'b1, mk(1'b0, 1, fl(48'h12000), NA, NA), 0);
    do_req(48'h22000, 1'b1, 1'b0, 1'b1, mk(1'b0, 2, fl(48'h22000), st(48'h22000), NA), 0);
    check_cnts(5, 2, 1, 6, 0);

    // Fill stalled for 5 cycles, then a reset in the middle of a stalled fill.
    do_reset();
    do_req(48'h3000, 1'b0, 1'b1, 1'b1, mk(1'b0, 1, fl(48'h3000), NA, NA), 5);
    mem_ready = 1'b0;
    req_addr = 48'h3040;
    req_we = 1'b0;
    req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
    end
    check_eq("abort_accept", 64'(got), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (mem_valid) got = 1'b1;
    end
    check_eq("abort_fill_seen", 64'(got), 64'd1);
    check_eq("abort_fill_addr", 64'(mem_addr), 64'h3040);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_mem_valid", 64'(mem_valid), 64'd0);
    check_eq("abort_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("abort_req_ready", 64'(req_ready), 64'd0);
    check_cnts(0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    mem_ready = 1'b1;
    resp_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) resp_seen = 1'b1;
    end
    check_eq("abort_no_resp", 64'(resp_seen), 64'd0);
    @(posedge clk);
    #1;
    do_req(48'h3040, 1'b0, 1'b1, 1'b1, mk(1'b0, 1, fl(48'h3040), NA, NA), 0);
    do_req(48'h3000, 1'b0, 1'b1, 1'b1, mk(1'b0, 1, fl(48'h3000), NA, NA), 0);
    check_cnts(2, 0, 0, 2, 0);

    // Counter saturation with a 4-bit counter width.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i == 0) do_req(48'h5000, 1'b0, 1'b1, 1'b1, mk(1'b0, 1, fl(48'h5000), NA, NA), 0);
      else        do_req(48'h5000, 1'b0, 1'b1, 1'b1, mk(1'b1, 0, NA, NA, NA), 0);
    end
    check_cnts(20, 0, 19, 1, 0);

    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
